// File: rtl/rdcla.sv
// -----------------------------------------------------------------------------
// rdcla - 32-bit registered recursive-doubling carry-lookahead adder
//
// Computes {cout, sum} = a + b + cin. The carry network is a 5-level
// parallel-prefix (Kogge-Stone style) tree. Operands are captured in an input
// register stage and the result is held in an output register stage, so the
// latency is two rising edges and a new operand set is accepted every cycle.
//
// Ports:
//   sum    out [31:0] registered sum (modulo 2^32)
//   cout   out        registered unsigned carry-out of bit 31
//   a      in  [31:0] operand A
//   b      in  [31:0] operand B
//   cin    in         carry-in
//   clk    in         clock, all state updates on the rising edge
//   rst_n  in         asynchronous active-low reset, clears every register
// -----------------------------------------------------------------------------
module rdcla (
    output logic [31:0] sum,
    output logic        cout,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    input  logic        clk,
    input  logic        rst_n
);

    localparam int WIDTH  = 32;
    localparam int LEVELS = 5;

    // ------------------------------------------------------------------
    // Stage 0: operand registers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             cin_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            cin_reg <= 1'b0;
        end else begin
            a_reg   <= a;
            b_reg   <= b;
            cin_reg <= cin;
        end
    end

    // ------------------------------------------------------------------
    // Bitwise generate / propagate
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] gen_bit;
    logic [WIDTH-1:0] prop_bit;

    assign gen_bit  = a_reg & b_reg;
    assign prop_bit = a_reg ^ b_reg;

    // ------------------------------------------------------------------
    // Prefix network. Row 0 is the bitwise (G,P) with cin folded into
    // bit 0, so the group generate out of the tree already includes the
    // carry-in and no separate carry-in correction is needed afterwards.
    // Row l combines each bit with the bit 2^(l-1) positions below it.
    // ------------------------------------------------------------------
    logic [LEVELS:0][WIDTH-1:0] gen_lvl;
    logic [LEVELS:0][WIDTH-1:0] prop_lvl;

    assign gen_lvl[0][0]  = gen_bit[0] | (prop_bit[0] & cin_reg);
    assign prop_lvl[0][0] = prop_bit[0];

    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_row0
            assign gen_lvl[0][gi]  = gen_bit[gi];
            assign prop_lvl[0][gi] = prop_bit[gi];
        end

        for (genvar gl = 1; gl <= LEVELS; gl++) begin : g_level
            localparam int DIST = 1 << (gl - 1);
            for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
                if (gi < DIST) begin : g_pass
                    // Nothing below to combine with: group already complete.
                    assign gen_lvl[gl][gi]  = gen_lvl[gl-1][gi];
                    assign prop_lvl[gl][gi] = prop_lvl[gl-1][gi];
                end else begin : g_comb
                    assign gen_lvl[gl][gi]  = gen_lvl[gl-1][gi]
                                            | (prop_lvl[gl-1][gi] & gen_lvl[gl-1][gi-DIST]);
                    assign prop_lvl[gl][gi] = prop_lvl[gl-1][gi] & prop_lvl[gl-1][gi-DIST];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Carries and sum. carry[i+1] is the group generate of bits [i:0].
    // ------------------------------------------------------------------
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_next;
    logic             cout_next;

    assign carry     = {gen_lvl[LEVELS], cin_reg};
    assign sum_next  = prop_bit ^ carry[WIDTH-1:0];
    assign cout_next = carry[WIDTH];

    // ------------------------------------------------------------------
    // Stage 1: result registers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg  <= '0;
            cout_reg <= 1'b0;
        end else begin
            sum_reg  <= sum_next;
            cout_reg <= cout_next;
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule

// File: tb/tb_rdcla.sv
// -----------------------------------------------------------------------------
// tb_rdcla - self-checking bench for rdcla.
// Directed vector table, hand-written reset/pipeline sequences, and a random
// stream compared against a 33-bit behavioural sum delayed by two edges.
// -----------------------------------------------------------------------------
module tb_rdcla;

    logic [31:0] sum;
    logic        cout;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        clk;
    logic        rst_n;

    int checks = 0;
    int errors = 0;

    rdcla dut (
        .sum   (sum),
        .cout  (cout),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .clk   (clk),
        .rst_n (rst_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] exp_sum;
        logic        exp_cout;
    } vec_t;

    vec_t vecs [10];

    // Advance past the next rising edge; sample/drive 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] exp_sum, input logic exp_cout);
        checks++;
        if (sum !== exp_sum || cout !== exp_cout) begin
            errors++;
            $display("FAIL %s: got sum=%08h cout=%0b, expected sum=%08h cout=%0b",
                     name, sum, cout, exp_sum, exp_cout);
        end else begin
            $display("ok   %s: sum=%08h cout=%0b", name, sum, cout);
        end
    endtask

    task automatic drive(input logic [31:0] va, input logic [31:0] vb, input logic vc);
        a   = va;
        b   = vb;
        cin = vc;
    endtask

    initial begin
        logic [32:0] exp_q [2];
        logic [32:0] model;

        vecs[0] = '{32'd123456789, 32'd987654321, 1'b0, 32'd1111111110, 1'b0};
        vecs[1] = '{32'hFFFFFFFF,  32'h00000000,  1'b1, 32'h00000000,   1'b1};
        vecs[2] = '{32'h7FFFFFFF,  32'h00000001,  1'b0, 32'h80000000,   1'b0};
        vecs[3] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b1, 32'hFFFFFFFF,   1'b1};
        vecs[4] = '{32'h00000000,  32'h00000000,  1'b1, 32'h00000001,   1'b0};
        vecs[5] = '{32'h80000000,  32'h80000000,  1'b0, 32'h00000000,   1'b1};
        vecs[6] = '{32'hAAAAAAAA,  32'h55555555,  1'b1, 32'h00000000,   1'b1};
        vecs[7] = '{32'h12345678,  32'h87654321,  1'b0, 32'h99999999,   1'b0};
        vecs[8] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0, 32'hFFFFFFFE,   1'b1};
        vecs[9] = '{32'h0000FFFF,  32'h00000001,  1'b0, 32'h00010000,   1'b0};

        // ---------------- Reset sequence ----------------
        rst_n = 1'b1;
        drive(32'hFFFFFFFF, 32'h00000001, 1'b0);
        #2 rst_n = 1'b0;                 // asserted before any clock edge
        #1 check("reset_async", 32'h0, 1'b0);
        step();
        step();
        check("reset_held", 32'h0, 1'b0);
        rst_n = 1'b1;
        step();
        check("release_first_edge", 32'h0, 1'b0);
        step();
        check("release_result", 32'h0, 1'b1);

        // ---------------- Directed table ----------------
        foreach (vecs[i]) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].cin);
            step();
            step();
            check($sformatf("vec%0d", i), vecs[i].exp_sum, vecs[i].exp_cout);
        end
        step();
        check("hold_stable", vecs[9].exp_sum, vecs[9].exp_cout);

        // ---------------- Pipelining: one pair per cycle ----------------
        drive(32'd1, 32'd2, 1'b0);
        step();
        drive(32'd10, 32'd20, 1'b0);
        step();
        check("pipe0", 32'd3, 1'b0);
        drive(32'hFFFF0000, 32'h0001FFFF, 1'b0);
        step();
        check("pipe1", 32'd30, 1'b0);
        drive(32'd0, 32'd0, 1'b0);
        step();
        check("pipe2", 32'h0000FFFF, 1'b1);

        // ---------------- Random stream with mid-stream reset ----------------
        // exp_q[1] holds the expected result of the operands driven one
        // iteration ago; its result appears after this iteration's edge.
        step();                          // flush: zero operands now in output
        exp_q[0] = '0;
        exp_q[1] = '0;
        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) begin
                rst_n = 1'b0;
                #1 check("midreset_clear", 32'h0, 1'b0);
                step();
                check("midreset_held", 32'h0, 1'b0);
                rst_n = 1'b1;
                // Operand register now holds zeros from reset.
                exp_q[1] = '0;
            end
            drive($urandom, $urandom, 1'($urandom_range(0, 1)));
            model    = {1'b0, a} + {1'b0, b} + {32'b0, cin};
            exp_q[0] = exp_q[1];
            exp_q[1] = model;
            step();
            checks++;
            if (sum !== exp_q[0][31:0] || cout !== exp_q[0][32]) begin
                errors++;
                $display("FAIL rand%0d: got sum=%08h cout=%0b, expected sum=%08h cout=%0b",
                         i, sum, cout, exp_q[0][31:0], exp_q[0][32]);
            end else if (i % 1000 == 0 || i == 5000) begin
                $display("ok   rand%0d: sum=%08h cout=%0b", i, sum, cout);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rdcla.md
# rdcla

32-bit registered recursive-doubling carry-lookahead adder: computes `sum`/`cout` = `a` + `b` + `cin` using a log2(32) = 5-level parallel-prefix (recursive doubling) carry network. Operands are captured in input registers and results are held in output registers. The block is the integer-add datapath element of the arithmetic unit. It accepts a new operand set every cycle.

## Interface
- No parameters; width fixed at 32.
- Port order in the instantiation: `sum, cout, a, b, cin, clk, rst_n`.
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low; one clock; reset is asynchronous and active-low.
- `a`  input  32  operand A, unsigned or two's complement.
- `b`  input  32  operand B.
- `cin`  input  1  carry-in.
- `sum`  output  32  registered sum bits [31:0].
- `cout`  output  1  registered carry-out of bit 31.

## Operation
- Stage 0, input register: on each `clk` rising edge, capture `a`, `b`, `cin` into `a_q`, `b_q`, `cin_q`.
- Bitwise terms: g[i] = a_q[i] & b_q[i]; p[i] = a_q[i] ^ b_q[i].
- Carry-in merge: position 0 generate is g[0] | (p[0] & cin_q), so the prefix yields carries that include `cin`.
- Recursive doubling network, 5 levels, distance d = 1, 2, 4, 8, 16.
  - Pair (G,P) at bit i with the pair at i-d: G' = G_i | (P_i & G_{i-d}); P' = P_i & P_{i-d}.
  - Bits with i < d pass through unchanged.
- Carries: c[0] = cin_q; c[i+1] = G[i:0] after level 5.
- Sum: s[i] = p[i] ^ c[i].
- Carry-out: c[32].
- Stage 1, output register: on the next rising edge, `sum` <= s, `cout` <= c[32].
- Arithmetic is modulo 2^32. `cout` is the unsigned carry. No overflow flag is produced.
- The functional result must equal {cout,sum} = a + b + cin (33-bit) for all inputs.
- No ripple chain anywhere. Critical path: 1 PG level + 5 prefix levels + 1 XOR.

## Timing
- Latency 2 rising edges: operands present before edge N appear on `sum`/`cout` after edge N+1.
- Throughput: one result per cycle, fully pipelined, no stall or handshake.
- Outputs are held stable between edges. If inputs are held constant, outputs stay constant from edge N+1 on.
- Reset, `rst_n` = 0:
  - Immediately and asynchronously clears `a_q`, `b_q`, `cin_q`, `sum`, `cout` to 0, regardless of `clk`.
  - Reset asserted mid-operation discards all in-flight results.
- Release: after `rst_n` rises, the first valid result appears 2 edges after inputs are applied. The edge between release and the first capture outputs 0 + 0 + 0 = 0.
- Inputs change synchronously to `clk`. No combinational path from inputs to outputs.

## Test plan
- Reset: assert `rst_n` = 0 with a = 32'hFFFFFFFF, b = 1 -> `sum` = 0, `cout` = 0 immediately; release, wait 2 edges -> `sum` = 0, `cout` = 1.
- Basic add, cin = 0: a = 32'd123456789, b = 32'd987654321 -> after 2 edges `sum` = 1111111110, `cout` = 0.
- Full carry propagation: a = 32'hFFFFFFFF, b = 0, cin = 1 -> `sum` = 0, `cout` = 1. Also a = 32'h7FFFFFFF, b = 1 -> `sum` = 32'h80000000, `cout` = 0.
- Max operands: a = b = 32'hFFFFFFFF, cin = 1 -> `sum` = 32'hFFFFFFFF, `cout` = 1.
- Pipelining: apply a new pair every cycle (1+2, 10+20, 32'hFFFF0000 + 32'h0001FFFF) -> outputs 3, 30, then `sum` = 32'h0000FFFF with `cout` = 1, on consecutive cycles starting 2 edges after the first.
- Random: 10,000 random a, b, cin, compared against a 33-bit behavioural sum with a 2-cycle delay. Include a reset pulse mid-stream and check that results clear and then resume.
